ram_sync: RTL and testbench
===========================

RAM_SYNC -- requirements
Module: ram_sync

Interface
REQ-001 SHALL have parameter DEPTH, default 5: address width in bits; the array holds 2**DEPTH words.
REQ-002 SHALL have parameter WIDTH, default 8: word width in bits; legal only as a multiple of 8.
REQ-003 SHALL have parameter LATENCY, default 1: read latency in clock edges; legal range 1..4.
REQ-004 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-006 SHALL have port cs_n, input, 1: chip select, active-low.
REQ-007 SHALL have port req, input, 1: a request is present this cycle.
REQ-008 SHALL have port we, input, 1: 1 means write, 0 means read.
REQ-009 SHALL have port addr, input, DEPTH: word address.
REQ-010 SHALL have port be, input, WIDTH/8: byte-enable mask for writes; bit i covers wdata[8i+7:8i].
REQ-011 SHALL have port wdata, input, WIDTH: write data.
REQ-012 SHALL have port clr, input, 1: request a full array clear.
REQ-013 SHALL have port ready, output, 1: the block accepts requests.
REQ-014 SHALL have port rdata, output, WIDTH: registered read data.
REQ-015 SHALL have port rvalid, output, 1: one-cycle strobe marking new rdata.

Function
REQ-016 SHALL implement a two-state FSM with states CLEAR and READY.
REQ-017 SHALL, in CLEAR, write zero to one word per rising edge, covering addresses 0 up to 2**DEPTH-1 in order using an internal counter.
REQ-018 SHALL move from CLEAR to READY on the edge that clears address 2**DEPTH-1, and reset the clear counter to 0 on that edge.
REQ-019 SHALL drive ready=1 only in READY.
REQ-020 SHALL accept a request on a rising edge only when req=1, cs_n=0, ready=1 and clr=0; all other requests are ignored with no side effect.
REQ-021 SHALL, for an accepted write, update only the bytes whose be bit is 1 on the accepting edge; be=0 leaves the word unchanged.
REQ-022 SHALL, for an accepted read, capture MEMORY[addr] on the accepting edge N.
REQ-023 SHALL pass a read accepted at edge N through a LATENCY-deep valid/data pipeline, present the data on rdata and assert rvalid for exactly one cycle after edge N+LATENCY-1.
REQ-024 SHALL accept back-to-back reads every cycle, with one rvalid pulse per accepted read, in order.
REQ-025 SHALL hold rdata between rvalid pulses; rdata is not cleared after a pulse.
REQ-026 SHALL return the newly written data for a read to address A accepted on the edge after a write to A.
REQ-027 SHALL return the value captured at acceptance for a read still in the pipeline when a later write to the same address is accepted (no retroactive update).
REQ-028 SHALL, when clr=1 at an edge in READY, enter CLEAR, drop ready and ignore any request presented on that edge.
REQ-029 SHALL flush all in-flight reads on entering CLEAR, so no rvalid is generated for them.
REQ-030 SHALL ignore clr while in CLEAR; the clear runs to completion.

Reset
REQ-031 SHALL, while rst=1 and independent of clk, set the FSM to CLEAR, the clear counter to 0, ready=0, rvalid=0, rdata=0 and the read pipeline to empty.
REQ-032 SHALL start clearing on the first rising edge after rst deasserts, so ready=1 after edge 2**DEPTH (edge 32 with DEPTH=5).
REQ-033 SHALL, when rst asserts mid-operation, abort any clear or read immediately; memory contents are then undefined until the following clear completes.

Verification
REQ-034 Bench SHALL apply reset with DEPTH=5, WIDTH=8, then read all 32 addresses -> ready rises after edge 32 and every read returns 0x00.
REQ-035 Bench SHALL, with WIDTH=16, write 0xABCD with be=11 to addr 3, then 0x1200 with be=10 to addr 3, then read addr 3 -> rdata=0x12CD.
REQ-036 Bench SHALL, with LATENCY=3, issue reads to addr 1, 2, 3 on consecutive edges N, N+1, N+2 -> rvalid is high after edges N+2, N+3, N+4 with the data in order.
REQ-037 Bench SHALL write 0x55 to addr 7 at edge N and read addr 7 at edge N+1 -> 0x55; with LATENCY=2, a read accepted at N followed by a write of 0x66 at N+1 -> read returns 0x55.
REQ-038 Bench SHALL, with a read in flight under LATENCY=2, pulse clr=1 together with req=1 -> no rvalid pulse, ready=0 for 32 cycles, write not performed, and all words read 0x00 afterwards.
REQ-039 Bench SHALL assert rst for one cycle during a CLEAR after 10 addresses -> ready=0 and rvalid=0 immediately, and a full 32-edge clear restarts from address 0.

Source files
------------

// File: rtl/ram_sync.sv
// Synchronous single-port RAM with byte enables, configurable read latency and a
// sequenced full-array clear that runs after reset or on demand.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_CLEAR | zeroing one word per edge from address 0 up; requests ignored
// ST_READY | accepting reads/writes; clr starts a new clear
module ram_sync #(
    parameter int DEPTH   = 5,
    parameter int WIDTH   = 8,
    parameter int LATENCY = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cs_n,
    input  logic               req,
    input  logic               we,
    input  logic [DEPTH-1:0]   addr,
    input  logic [WIDTH/8-1:0] be,
    input  logic [WIDTH-1:0]   wdata,
    input  logic               clr,
    output logic               ready,
    output logic [WIDTH-1:0]   rdata,
    output logic               rvalid
);
    localparam int NBYTE = WIDTH / 8;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    logic [0:0]       state;
    logic [DEPTH-1:0] clr_cnt;
    logic             clr_last;
    logic             accept;
    logic             acc_rd;
    logic             acc_wr;
    logic             clr_go;

    logic [WIDTH-1:0] mem [2**DEPTH];

    logic [LATENCY-1:0] pipe_vld;
    logic [WIDTH-1:0]   pipe_dat [LATENCY];

    assign ready    = (state == ST_READY);
    assign accept   = req & ~cs_n & ready & ~clr;
    assign acc_wr   = accept & we;
    assign acc_rd   = accept & ~we;
    assign clr_go   = ready & clr;
    assign clr_last = (clr_cnt == {DEPTH{1'b1}});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_CLEAR;
            clr_cnt <= '0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    if (clr_last) begin
                        clr_cnt <= '0;
                        state   <= ST_READY;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end
                ST_READY: begin
                    if (clr) state <= ST_CLEAR;
                end
                default: state <= ST_CLEAR;
            endcase
        end
    end

    // The array itself is never reset; its contents are only trusted after a clear.
    always_ff @(posedge clk) begin
        if (state == ST_CLEAR) begin
            mem[clr_cnt] <= '0;
        end else if (acc_wr) begin
            for (int i = 0; i < NBYTE; i++) begin
                if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    // Data stages only load behind a valid so rdata holds between pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_vld <= '0;
            for (int k = 0; k < LATENCY; k++) pipe_dat[k] <= '0;
        end else begin
            pipe_vld[0] <= acc_rd;
            if (acc_rd) pipe_dat[0] <= mem[addr];
            for (int k = 1; k < LATENCY; k++) begin
                pipe_vld[k] <= pipe_vld[k-1];
                if (pipe_vld[k-1]) pipe_dat[k] <= pipe_dat[k-1];
            end
            if (clr_go) pipe_vld <= '0;
        end
    end

    assign rvalid = pipe_vld[LATENCY-1];
    assign rdata  = pipe_dat[LATENCY-1];

endmodule

// File: tb/tb_ram_sync.sv
// Self-checking bench for ram_sync: three instances (8-bit/lat1, 16-bit/lat3,
// 16-bit/lat2) share one stimulus stream and are checked against a scoreboard model.
module tb_ram_sync;
    logic        clk = 1'b0;
    logic        rst;
    logic        cs_n, req, we, clr;
    logic [4:0]  addr;
    logic [1:0]  be;
    logic [15:0] wdata;

    logic        rdy0, rdy1, rdy2, rv0, rv1, rv2;
    logic [7:0]  rd0;
    logic [15:0] rd1, rd2;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ram_sync #(.DEPTH(5), .WIDTH(8), .LATENCY(1)) u_w8 (
        .clk(clk), .rst(rst), .cs_n(cs_n), .req(req), .we(we), .addr(addr),
        .be(be[0:0]), .wdata(wdata[7:0]), .clr(clr),
        .ready(rdy0), .rdata(rd0), .rvalid(rv0));

    ram_sync #(.DEPTH(5), .WIDTH(16), .LATENCY(3)) u_l3 (
        .clk(clk), .rst(rst), .cs_n(cs_n), .req(req), .we(we), .addr(addr),
        .be(be), .wdata(wdata), .clr(clr),
        .ready(rdy1), .rdata(rd1), .rvalid(rv1));

    ram_sync #(.DEPTH(5), .WIDTH(16), .LATENCY(2)) u_l2 (
        .clk(clk), .rst(rst), .cs_n(cs_n), .req(req), .we(we), .addr(addr),
        .be(be), .wdata(wdata), .clr(clr),
        .ready(rdy2), .rdata(rd2), .rvalid(rv2));

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard model: each accepted read becomes an entry due at a given edge.
    typedef struct {
        int          inst;
        int          due;
        logic [15:0] data;
    } ent_t;

    ent_t        pend[$];
    logic [15:0] mmem [32];
    int          clr_rem = 32;
    int          ecount  = 0;
    int          lat [3] = '{1, 3, 2};
    logic        exp_rv [3];
    logic [15:0] exp_rd [3];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            clr_rem = 32;
            pend.delete();
            for (int k = 0; k < 3; k++) begin
                exp_rv[k] = 1'b0;
                exp_rd[k] = '0;
            end
            for (int a = 0; a < 32; a++) mmem[a] = '0;
        end else begin
            ecount++;
            if (clr_rem > 0) begin
                clr_rem--;
            end else if (clr) begin
                clr_rem = 32;
                pend.delete();
                for (int a = 0; a < 32; a++) mmem[a] = '0;
            end else if (req && !cs_n) begin
                if (we) begin
                    for (int b = 0; b < 2; b++) begin
                        if (be[b]) mmem[addr][8*b +: 8] = wdata[8*b +: 8];
                    end
                end else begin
                    for (int k = 0; k < 3; k++) begin
                        ent_t e;
                        e.inst = k;
                        e.due  = ecount + lat[k] - 1;
                        e.data = mmem[addr];
                        pend.push_back(e);
                    end
                end
            end
            for (int k = 0; k < 3; k++) exp_rv[k] = 1'b0;
            foreach (pend[i]) begin
                if (pend[i].due == ecount) begin
                    exp_rv[pend[i].inst] = 1'b1;
                    exp_rd[pend[i].inst] = pend[i].data;
                end
            end
            for (int i = pend.size() - 1; i >= 0; i--) begin
                if (pend[i].due <= ecount) pend.delete(i);
            end
        end
    end

    always @(negedge clk) begin
        chk("ready_w8", {15'd0, rdy0}, {15'd0, clr_rem == 0});
        chk("ready_l3", {15'd0, rdy1}, {15'd0, clr_rem == 0});
        chk("ready_l2", {15'd0, rdy2}, {15'd0, clr_rem == 0});
        chk("rvalid_w8", {15'd0, rv0}, {15'd0, exp_rv[0]});
        chk("rvalid_l3", {15'd0, rv1}, {15'd0, exp_rv[1]});
        chk("rvalid_l2", {15'd0, rv2}, {15'd0, exp_rv[2]});
        chk("rdata_w8", {8'd0, rd0}, {8'd0, exp_rd[0][7:0]});
        chk("rdata_l3", rd1, exp_rd[1]);
        chk("rdata_l2", rd2, exp_rd[2]);
    end

    task automatic idle();
        req = 1'b0; we = 1'b0; clr = 1'b0; cs_n = 1'b0;
        be = 2'b00; wdata = '0; addr = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wr(input logic [4:0] a, input logic [15:0] d, input logic [1:0] b);
        req = 1'b1; we = 1'b1; addr = a; wdata = d; be = b;
        tick();
        idle();
    endtask

    task automatic rd(input logic [4:0] a);
        req = 1'b1; we = 1'b0; addr = a;
        tick();
        idle();
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!rdy0 && n < 40) begin
            tick();
            n++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        rst = 1'b1;
        idle();
        repeat (3) tick();
        chk("rst_ready", {15'd0, rdy0}, 16'd0);
        chk("rst_rvalid", {15'd0, rv1}, 16'd0);
        chk("rst_rdata", rd1, 16'h0000);

        // Ready must rise only after the 32nd edge following reset release.
        #2 rst = 1'b0;
        wait_ready(n);
        chk("rst_clear_edges", 16'(n), 16'd32);

        for (int a = 0; a < 32; a++) rd(5'(a));
        repeat (4) tick();
        chk("init_rdata_w8", {8'd0, rd0}, 16'h0000);
        chk("init_rdata_l3", rd1, 16'h0000);

        wr(5'd3, 16'hABCD, 2'b11);
        wr(5'd3, 16'h1200, 2'b10);
        rd(5'd3);
        repeat (3) tick();
        chk("be_merge_l3", rd1, 16'h12CD);
        chk("be_merge_l2", rd2, 16'h12CD);
        chk("be_merge_w8", {8'd0, rd0}, 16'h00CD);

        wr(5'd1, 16'h1111, 2'b11);
        wr(5'd2, 16'h2222, 2'b11);
        wr(5'd3, 16'h3333, 2'b11);
        rd(5'd1);
        chk("l3_n0_rvalid", {15'd0, rv1}, 16'd0);
        rd(5'd2);
        chk("l3_n1_rvalid", {15'd0, rv1}, 16'd0);
        rd(5'd3);
        chk("l3_n2_rvalid", {15'd0, rv1}, 16'd1);
        chk("l3_n2_rdata", rd1, 16'h1111);
        tick();
        chk("l3_n3_rdata", rd1, 16'h2222);
        tick();
        chk("l3_n4_rvalid", {15'd0, rv1}, 16'd1);
        chk("l3_n4_rdata", rd1, 16'h3333);
        tick();
        chk("l3_hold_rvalid", {15'd0, rv1}, 16'd0);
        chk("l3_hold_rdata", rd1, 16'h3333);

        wr(5'd7, 16'h0055, 2'b11);
        rd(5'd7);
        chk("raw_w8_rvalid", {15'd0, rv0}, 16'd1);
        chk("raw_w8_rdata", {8'd0, rd0}, 16'h0055);
        rd(5'd7);
        wr(5'd7, 16'h0066, 2'b11);
        chk("war_l2_rvalid", {15'd0, rv2}, 16'd1);
        chk("war_l2_rdata", rd2, 16'h0055);
        repeat (3) tick();

        cs_n = 1'b1;
        wr(5'd7, 16'h7777, 2'b11);
        wr(5'd7, 16'h8888, 2'b00);
        rd(5'd7);
        chk("ignored_wr_w8", {8'd0, rd0}, 16'h0066);
        repeat (3) tick();

        // Clear with a read in flight and a colliding write on the clr edge.
        wr(5'd5, 16'h5A5A, 2'b11);
        req = 1'b1; we = 1'b0; addr = 5'd7;
        tick();
        clr = 1'b1; req = 1'b1; we = 1'b1; addr = 5'd5; wdata = 16'hBEEF; be = 2'b11;
        tick();
        idle();
        chk("clr_flush_l2", {15'd0, rv2}, 16'd0);
        chk("clr_flush_l3", {15'd0, rv1}, 16'd0);
        chk("clr_ready", {15'd0, rdy0}, 16'd0);
        n = 0;
        while (!rdy0 && n < 40) begin
            n++;
            clr = (n == 10);
            tick();
        end
        idle();
        chk("clr_low_cycles", 16'(n), 16'd32);
        rd(5'd5);
        tick();
        tick();
        chk("clr_addr5_l3", rd1, 16'h0000);
        for (int a = 0; a < 32; a++) rd(5'(a));
        repeat (4) tick();

        // Reset in the middle of a clear restarts it from address 0.
        wr(5'd9, 16'h9999, 2'b11);
        clr = 1'b1;
        tick();
        idle();
        repeat (10) tick();
        #2 rst = 1'b1;
        #1;
        chk("midrst_ready", {15'd0, rdy0}, 16'd0);
        chk("midrst_rvalid", {15'd0, rv2}, 16'd0);
        tick();
        #2 rst = 1'b0;
        wait_ready(n);
        chk("midrst_clear_edges", 16'(n), 16'd32);
        rd(5'd9);
        chk("midrst_addr9_w8", {8'd0, rd0}, 16'h0000);
        for (int a = 0; a < 32; a++) rd(5'(a));
        repeat (4) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
